// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifu_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } ifu_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    // Immediate field positions inside a LEGv8 branch encoding.
    localparam int IMM26_MSB = 25;   // B:          imm26 = instr[25:0]
    localparam int IMM19_MSB = 23;   // CBZ/B.cond: imm19 = instr[23:5]
    localparam int IMM19_LSB = 5;

endpackage

// File: rtl/extend.sv
// Sign extension of an IN_W-bit field to OUT_W bits.
// Latency: combinational.
// Backpressure: none.
// Ports: i_val (narrow field), o_val (sign-extended result).
module extend #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 64
) (
    input  logic [IN_W-1:0]  i_val,
    output logic [OUT_W-1:0] o_val
);

    assign o_val = {{(OUT_W - IN_W){i_val[IN_W-1]}}, i_val};

endmodule

// File: rtl/ifu_branch_target.sv
// Next-PC computation: PC+4, or PC + (sign-extended imm26/imm19 << 2).
// Latency: combinational.
// Backpressure: none.
// Ports: i_pc, i_imm (instruction[25:0]), i_br_taken, i_uncond_br -> o_next_pc.
module ifu_branch_target
    import ifu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [IMM26_MSB:0] i_imm,
    input  logic               i_br_taken,
    input  logic               i_uncond_br,
    output logic [ADDR_W-1:0]  o_next_pc
);

    localparam int IMM19_W = IMM19_MSB - IMM19_LSB + 1;

    logic [ADDR_W-1:0] w_imm26_ext;
    logic [ADDR_W-1:0] w_imm19_ext;
    logic [ADDR_W-1:0] w_offset;

    extend #(.IN_W(IMM26_MSB + 1), .OUT_W(ADDR_W)) u_ext26 (
        .i_val (i_imm),
        .o_val (w_imm26_ext)
    );

    extend #(.IN_W(IMM19_W), .OUT_W(ADDR_W)) u_ext19 (
        .i_val (i_imm[IMM19_MSB:IMM19_LSB]),
        .o_val (w_imm19_ext)
    );

    // Word offset to byte offset; the add wraps modulo 2^ADDR_W by design.
    assign w_offset  = (i_uncond_br ? w_imm26_ext : w_imm19_ext) << 2;
    assign o_next_pc = i_br_taken ? (i_pc + w_offset) : (i_pc + ADDR_W'(PC_STEP));

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch front end: owns the PC, fetches over req/ready, holds the word until retire.
// Latency: instruction valid 1 cycle after the ready cycle; new request 1 cycle after retire.
// Backpressure: request held stable until imem_ready; instruction held until retire.
// Ports: clk/reset (sync, active-high); imem_req/imem_addr/imem_ready/imem_rdata to memory;
//        instruction/instr_valid/pc to datapath; retire/br_taken/uncond_br from datapath/control.
// Optional: IFU_PERF_COUNT_EN adds retired_count and taken_br_count (32-bit, wrapping).
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    input  logic               retire,
    input  logic               br_taken,
    input  logic               uncond_br
`ifdef IFU_PERF_COUNT_EN
    ,
    output logic [31:0]        retired_count,
    output logic [31:0]        taken_br_count
`endif
);

    ifu_state_t         r_state;
    ifu_state_t         w_state_nxt;
    logic               r_req;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               w_capture;
    logic               w_retire;
    logic [ADDR_W-1:0]  w_next_pc;

    // r_req is low for one cycle after reset even though the state is FETCH,
    // so a late response to an abandoned fetch lands while req=0 and is dropped.
    assign w_capture = (r_state == FETCH) && r_req && imem_ready;
    assign w_retire  = (r_state == HOLD) && r_valid && retire;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (w_capture) w_state_nxt = HOLD;
            HOLD:    if (w_retire)  w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    ifu_branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
        .i_pc        (r_pc),
        .i_imm       (r_instr[IMM26_MSB:0]),
        .i_br_taken  (br_taken),
        .i_uncond_br (uncond_br),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_req   <= 1'b0;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == FETCH);
            if (w_capture) begin
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_retire) begin
                r_pc    <= w_next_pc;
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign instr_valid = r_valid;

`ifdef IFU_PERF_COUNT_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_taken_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_cnt <= '0;
            r_taken_cnt   <= '0;
        end else if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
            if (br_taken) r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign retired_count  = r_retired_cnt;
    assign taken_br_count = r_taken_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed walk through the fetch/branch scenarios,
// then randomized memory latency, retire and branch traffic against a reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic        retire = 1'b0;
    logic        br_taken = 1'b0;
    logic        uncond_br = 1'b0;
`ifdef IFU_PERF_COUNT_EN
    logic [31:0] retired_count;
    logic [31:0] taken_br_count;
`endif

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .retire      (retire),
        .br_taken    (br_taken),
        .uncond_br   (uncond_br)
`ifdef IFU_PERF_COUNT_EN
        ,
        .retired_count  (retired_count),
        .taken_br_count (taken_br_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks what the fetch unit must be showing, from the architectural rules:
    // a word is either held (awaiting retire) or being requested; after reset
    // one idle cycle precedes the first request.
    logic [63:0] m_pc = 64'h0;
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_req = 1'b0;
    logic        m_live = 1'b0;
    logic [31:0] m_ret = 32'h0;
    logic [31:0] m_taken = 32'h0;

    function automatic logic [63:0] model_next(input logic [63:0] p, input logic [31:0] ins,
                                               input logic t, input logic u);
        longint off;
        if (!t) return p + 64'd4;
        if (u) begin
            off = longint'(ins[25:0]);
            if (ins[25]) off = off - (longint'(1) << 26);
        end else begin
            off = longint'(ins[23:5]);
            if (ins[23]) off = off - (longint'(1) << 19);
        end
        return p + 64'(off * 4);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 64'h0; m_instr = 32'h0; m_valid = 1'b0; m_req = 1'b0;
            m_ret = 32'h0; m_taken = 32'h0; m_live = 1'b1;
        end else if (m_live) begin
            if (!m_valid) begin
                if (m_req && imem_ready) begin
                    m_instr = imem_rdata; m_valid = 1'b1; m_req = 1'b0;
                end else begin
                    m_req = 1'b1;
                end
            end else if (retire) begin
                m_pc = model_next(m_pc, m_instr, br_taken, uncond_br);
                m_valid = 1'b0; m_req = 1'b1;
                m_ret = m_ret + 32'd1;
                if (br_taken) m_taken = m_taken + 32'd1;
            end
        end
    end

    // Per-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_req",   64'(imem_req),    64'(m_req));
            chk("cyc_addr",  imem_addr,        m_pc);
            chk("cyc_pc",    pc,               m_pc);
            chk("cyc_valid", 64'(instr_valid), 64'(m_valid));
            chk("cyc_instr", 64'(instruction), 64'(m_instr));
`ifdef IFU_PERF_COUNT_EN
            chk("cyc_retcnt", 64'(retired_count),  64'(m_ret));
            chk("cyc_brcnt",  64'(taken_br_count), 64'(m_taken));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Wait for a request at exp_addr, hold ready low for 'delay' cycles, then respond.
    task automatic serve(input logic [31:0] d, input int delay, input logic [63:0] exp_addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            cyc();
            n++;
        end
        chk("req_seen", 64'(imem_req), 64'h1);
        chk("req_addr", imem_addr, exp_addr);
        chk("model_pc", m_pc, exp_addr);
        for (int i = 0; i < delay; i++) begin
            imem_ready = 1'b0;
            cyc();
            chk("stall_req",   64'(imem_req),    64'h1);
            chk("stall_addr",  imem_addr,        exp_addr);
            chk("stall_valid", 64'(instr_valid), 64'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = d;
        cyc();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("cap_instr", 64'(instruction), 64'(d));
        chk("cap_valid", 64'(instr_valid), 64'h1);
        chk("cap_req",   64'(imem_req),    64'h0);
    endtask

    task automatic retire_it(input logic t, input logic u);
        retire = 1'b1; br_taken = t; uncond_br = u;
        cyc();
        retire = 1'b0; br_taken = 1'($urandom); uncond_br = 1'($urandom);
    endtask

    initial begin
        // Reset for two cycles.
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_req",   64'(imem_req),    64'h0);
        chk("rst_valid", 64'(instr_valid), 64'h0);
        chk("rst_instr", 64'(instruction), 64'h0);
        chk("rst_pc",    pc,               64'h0);
        reset = 1'b0;

        // Zero-wait fetch at RESET_PC, then sequential retires.
        serve(32'h91000400, 0, 64'h0);
        retire_it(1'b0, 1'b0);
        serve(32'h91000400, 0, 64'h4);
        retire_it(1'b0, 1'b0);
        // CBZ imm19=3, not taken -> 0x0C.
        serve(32'hB4000060, 0, 64'h8);
        retire_it(1'b0, 1'b0);
        serve(32'h91000400, 0, 64'hC);
        retire_it(1'b0, 1'b1);
        // B imm26=-2 at 0x10 -> 0x08.
        serve(32'h17FFFFFE, 0, 64'h10);
        retire_it(1'b1, 1'b1);
        // CBZ imm19=3 taken at 0x08 -> 0x14.
        serve(32'hB4000060, 0, 64'h8);
        retire_it(1'b1, 1'b0);
        // Three-cycle stall at 0x14, then B imm26=3 -> 0x20.
        serve(32'h14000003, 3, 64'h14);
        retire_it(1'b1, 1'b1);
        chk("addr_0x20", imem_addr, 64'h20);

        // Retire while fetching is ignored.
        retire = 1'b1; br_taken = 1'b1; uncond_br = 1'b1;
        cyc();
        retire = 1'b0;
        chk("fetch_retire_pc",    pc,               64'h20);
        chk("fetch_retire_valid", 64'(instr_valid), 64'h0);

        // Reset while waiting on 0x20; late response right after reset is dropped.
        reset = 1'b1;
        cyc();
        chk("midrst_req", 64'(imem_req), 64'h0);
        chk("midrst_pc",  pc,            64'h0);
        reset = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        cyc();
        imem_ready = 1'b0;
        chk("stale_valid", 64'(instr_valid), 64'h0);
        chk("stale_req",   64'(imem_req),    64'h1);
        chk("stale_addr",  imem_addr,        64'h0);
        serve(32'h91000400, 1, 64'h0);
        retire_it(1'b0, 1'b0);

        // Randomized traffic; the per-cycle compare carries the checking.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 249) == 0);
            imem_ready = ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            retire     = ($urandom_range(0, 2) == 0);
            br_taken   = 1'($urandom);
            uncond_br  = 1'($urandom);
            cyc();
        end
        reset = 1'b0; imem_ready = 1'b0; retire = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front end of the single-cycle LEGv8 core. Owns the program counter, fetches 32-bit instructions from instruction memory over a req/ready handshake, and presents each instruction to the datapath and control unit. Waits for the datapath to retire the instruction, then computes the next PC from the branch decision (PC+4, B imm26, or CBZ/B.cond imm19).

Parameters:
ADDR_W, 64, PC and instruction-address width
RESET_PC, 64'h0, PC loaded on reset

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address; always equals pc
imem_ready  input  1  memory response valid this cycle
imem_rdata  input  32  fetched instruction word, valid when imem_ready=1
instruction  output  32  registered instruction presented to datapath/control
instr_valid  output  1  instruction holds a fetched, unretired word
pc  output  ADDR_W  address of the current instruction
retire  input  1  datapath has completed the presented instruction this cycle
br_taken  input  1  from control: take branch (sampled only on accepted retire)
uncond_br  input  1  from control: 1 = imm26 (B), 0 = imm19 (CBZ/B.cond)

Behaviour:
- Reset: while reset=1 at a posedge: pc<=RESET_PC, instruction<=32'h0, instr_valid<=0, state<=FETCH. Outputs are registered, so imem_req=0 and instr_valid=0 during any cycle in which reset is asserted and the posedge following it.
- FSM states: FETCH, HOLD.
- FETCH: imem_req=1, imem_addr=pc, both stable until the handshake.
  - imem_ready=1: instruction<=imem_rdata, instr_valid<=1, next state HOLD.
  - Zero-wait memory (ready in the first FETCH cycle) gives instr_valid one cycle after the request.
  - imem_ready=0: remain in FETCH with unchanged pc and addr.
- HOLD: imem_req=0; instruction and pc held.
  - retire=1 (accepted retire): pc<=next_pc, instr_valid<=0, next state FETCH.
  - retire=0: remain in HOLD.
- next_pc:
  - br_taken=0: pc+4.
  - br_taken=1, uncond_br=1: pc + (sign_extend(instruction[25:0])<<2).
  - br_taken=1, uncond_br=0: pc + (sign_extend(instruction[23:5])<<2).
- Arithmetic: ADDR_W-bit, wraps modulo 2^ADDR_W with no fault. Negative offsets are legal. Offset 0 (branch to self) is legal and refetches the same address.
- Ignored inputs:
  - retire in FETCH or while instr_valid=0.
  - br_taken and uncond_br outside an accepted retire.
  - imem_ready while imem_req=0 (stale response).
- Reset mid-operation: an outstanding fetch is abandoned. The first request after reset is to RESET_PC, and any late response is discarded by the rule above.
- Memory contract: memory must drop any outstanding request when imem_req falls. imem_rdata need only be valid in the ready cycle.

Optional Feature:
IFU_PERF_COUNT_EN
- Defined: adds outputs retired_count[31:0] and taken_br_count[31:0], both reset to 0.
  - retired_count increments on each accepted retire.
  - taken_br_count increments on each accepted retire with br_taken=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ifu_pkg:
  - state enum {FETCH, HOLD}
  - INSTR_W=32, PC_STEP=4
  - field constants IMM26_MSB=25, IMM19_MSB=23, IMM19_LSB=5
- Sub-module ifu_branch_target: purely combinational. Computes next_pc from pc, instruction, br_taken and uncond_br (sign-extend, shift left 2, add). Reuses the existing extend module for sign extension.

Test Plan:
- Reset 2 cycles, then deassert; imem_ready=1 in the first request cycle with rdata=32'h91000400 → imem_addr=0, imem_req=1; next cycle instruction=32'h91000400, instr_valid=1, imem_req=0.
- Two accepted retires with br_taken=0 → subsequent fetch addresses 0x4 then 0x8; pc tracks each fetch.
- pc=0x10, instruction=32'h17FFFFFE (B, imm26=-2), retire+br_taken+uncond_br → next imem_addr=0x08.
- pc=0x8, instruction=32'hB4000060 (CBZ, imm19=3), retire+br_taken, uncond_br=0 → imem_addr=0x14; repeat with br_taken=0 → imem_addr=0x0C.
- imem_ready held low 3 cycles in FETCH → imem_req=1, imem_addr stable, instr_valid=0 throughout; data captured on the 4th cycle when ready rises.
- reset asserted while waiting on fetch at 0x20, then imem_ready pulsed in the cycle after reset deasserts with junk data → junk not captured; new request at RESET_PC=0. Also retire pulsed in FETCH → no pc change.
